// File: rtl/timer_cmp_irq_pkg.sv
// Shared timer definitions: register select bit positions and compare reset value.
package timer_cmp_irq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CNT_W    = 2 * DATA_W;

    // One-hot register select bit indices (shared with the counter block)
    localparam int unsigned SEL_TDR0  = 1;
    localparam int unsigned SEL_TDR1  = 2;
    localparam int unsigned SEL_TCMP0 = 3;
    localparam int unsigned SEL_TCMP1 = 4;
    localparam int unsigned SEL_TIER  = 5;
    localparam int unsigned SEL_TISR  = 6;

    // Compare register comes out of reset at all-ones
    localparam logic [CNT_W-1:0] TCMP_RST = '1;

endpackage

// File: rtl/timer_cmp_irq.sv
// Timer compare/interrupt block: 64-bit compare register, sticky match flag,
// interrupt enable, registered read mux with coherent high-word snapshot.
module timer_cmp_irq
    import timer_cmp_irq_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_W,
    parameter int unsigned CNT_SIZE  = 2 * DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [7:0]           reg_sel,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic [CNT_SIZE-1:0]  cnt,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 irq
);

    logic [CNT_SIZE-1:0]  r_tcmp;
    logic                 r_tier;
    logic                 r_tisr;
    logic [DATA_SIZE-1:0] r_snap;
    logic [DATA_SIZE-1:0] r_rdata;

    logic                 w_match;
    logic                 w_tisr_clr;
    logic [DATA_SIZE-1:0] w_rd_mux;

    // Match against the compare value registered before this edge
    always_comb begin
        w_match    = (cnt == r_tcmp);
        w_tisr_clr = wr_en && reg_sel[SEL_TISR] && wdata[0];
    end

    // Read mux: sources are all pre-write register values
    always_comb begin
        w_rd_mux = '0;
        if (reg_sel[SEL_TDR0])
            w_rd_mux = cnt[DATA_SIZE-1:0];
        else if (reg_sel[SEL_TDR1])
            w_rd_mux = r_snap;
        else if (reg_sel[SEL_TCMP0])
            w_rd_mux = r_tcmp[DATA_SIZE-1:0];
        else if (reg_sel[SEL_TCMP1])
            w_rd_mux = r_tcmp[CNT_SIZE-1:DATA_SIZE];
        else if (reg_sel[SEL_TIER])
            w_rd_mux = {{(DATA_SIZE-1){1'b0}}, r_tier};
        else if (reg_sel[SEL_TISR])
            w_rd_mux = {{(DATA_SIZE-1){1'b0}}, r_tisr};
    end

    // Compare register halves and interrupt enable writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcmp <= TCMP_RST;
            r_tier <= 1'b0;
        end else if (wr_en) begin
            if (reg_sel[SEL_TCMP0])
                r_tcmp[DATA_SIZE-1:0] <= wdata;
            if (reg_sel[SEL_TCMP1])
                r_tcmp[CNT_SIZE-1:DATA_SIZE] <= wdata;
            if (reg_sel[SEL_TIER])
                r_tier <= wdata[0];
        end
    end

    // Sticky status flag: match set takes priority over write-1-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tisr <= 1'b0;
        else if (w_match)
            r_tisr <= 1'b1;
        else if (w_tisr_clr)
            r_tisr <= 1'b0;
    end

    // Registered read data; a TDR0 read also latches the counter high word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_snap  <= '0;
        end else if (rd_en) begin
            r_rdata <= w_rd_mux;
            if (reg_sel[SEL_TDR0])
                r_snap <= cnt[CNT_SIZE-1:DATA_SIZE];
        end
    end

    // Outputs driven straight from registers
    always_comb begin
        rdata = r_rdata;
        irq   = r_tisr & r_tier;
    end

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Self-checking bench for timer_cmp_irq: directed scenarios plus random
// register traffic checked against a behavioural register model.
module tb_timer_cmp_irq;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  reg_sel;
    logic [31:0] wdata;
    logic [63:0] cnt;
    logic [31:0] rdata;
    logic        irq;

    int unsigned errors;
    int unsigned checks;

    // Reference model state
    logic [63:0] m_tcmp;
    logic        m_tier;
    logic        m_tisr;
    logic [31:0] m_snap;
    logic [31:0] m_rdata;

    localparam logic [7:0] S_TDR0  = 8'h02;
    localparam logic [7:0] S_TDR1  = 8'h04;
    localparam logic [7:0] S_TCMP0 = 8'h08;
    localparam logic [7:0] S_TCMP1 = 8'h10;
    localparam logic [7:0] S_TIER  = 8'h20;
    localparam logic [7:0] S_TISR  = 8'h40;

    timer_cmp_irq #(.DATA_SIZE(32), .CNT_SIZE(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .reg_sel (reg_sel),
        .wdata   (wdata),
        .cnt     (cnt),
        .rdata   (rdata),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [7:0] sel, input logic [63:0] c);
        if (sel == S_TDR0)  return c[31:0];
        if (sel == S_TDR1)  return m_snap;
        if (sel == S_TCMP0) return m_tcmp[31:0];
        if (sel == S_TCMP1) return m_tcmp[63:32];
        if (sel == S_TIER)  return {31'b0, m_tier};
        if (sel == S_TISR)  return {31'b0, m_tisr};
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_tcmp  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_tier  = 1'b0;
        m_tisr  = 1'b0;
        m_snap  = 32'h0;
        m_rdata = 32'h0;
    endtask

    // One clock cycle of bus activity; model predicts, then DUT is checked #1 after the edge
    task automatic cyc(input logic we, input logic re, input logic [7:0] sel,
                       input logic [31:0] wd, input logic [63:0] c);
        logic [31:0] n_rdata;
        logic [31:0] n_snap;
        logic [63:0] n_tcmp;
        logic        n_tier;
        logic        n_tisr;
        wr_en   = we;
        rd_en   = re;
        reg_sel = sel;
        wdata   = wd;
        cnt     = c;
        n_rdata = re ? mread(sel, c) : m_rdata;
        n_snap  = (re && sel[1]) ? c[63:32] : m_snap;
        n_tcmp  = m_tcmp;
        if (we && sel[3]) n_tcmp[31:0]  = wd;
        if (we && sel[4]) n_tcmp[63:32] = wd;
        n_tier  = (we && sel[5]) ? wd[0] : m_tier;
        if (c == m_tcmp)                n_tisr = 1'b1;
        else if (we && sel[6] && wd[0]) n_tisr = 1'b0;
        else                            n_tisr = m_tisr;
        @(posedge clk);
        #1;
        m_rdata = n_rdata;
        m_snap  = n_snap;
        m_tcmp  = n_tcmp;
        m_tier  = n_tier;
        m_tisr  = n_tisr;
        chk("rdata", {32'h0, rdata}, {32'h0, m_rdata});
        chk("irq", {63'h0, irq}, {63'h0, m_tisr & m_tier});
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [7:0]  sel;
        logic [31:0] wd;
        logic [63:0] c;
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        reg_sel = 8'h00;
        wdata   = 32'h0;
        cnt     = 64'h0;
        model_reset();
        #12;
        rst_n = 1'b1;
        chk("reset_rdata", {32'h0, rdata}, 64'h0);
        chk("reset_irq", {63'h0, irq}, 64'h0);

        // Reset compare value visible on read
        cyc(1'b0, 1'b1, S_TCMP0, 32'h0, 64'h0);
        chk("rst_tcmp0", {32'h0, rdata}, 64'hFFFF_FFFF);
        cyc(1'b0, 1'b1, S_TDR1, 32'h0, 64'h0);
        chk("tdr1_no_snap", {32'h0, rdata}, 64'h0);

        // Compare match sets TISR and raises irq, sticky afterwards
        cyc(1'b1, 1'b0, S_TCMP0, 32'h10, 64'h0);
        cyc(1'b1, 1'b0, S_TCMP1, 32'h0, 64'h0);
        cyc(1'b1, 1'b0, S_TIER, 32'h1, 64'h0);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 64'h0E);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 64'h0F);
        chk("pre_match_irq", {63'h0, irq}, 64'h0);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 64'h10);
        chk("match_irq", {63'h0, irq}, 64'h1);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 64'h11);
        cyc(1'b0, 1'b1, S_TISR, 32'h0, 64'h12);
        chk("sticky_tisr", {32'h0, rdata}, 64'h1);

        // Write-0 leaves TISR, write-1 clears it
        cyc(1'b1, 1'b0, S_TISR, 32'h0, 64'h20);
        chk("w0_no_clear", {63'h0, irq}, 64'h1);
        cyc(1'b1, 1'b0, S_TISR, 32'h1, 64'h20);
        chk("w1_clear", {63'h0, irq}, 64'h0);

        // Match wins over a simultaneous clear
        cyc(1'b1, 1'b0, S_TISR, 32'h1, 64'h10);
        chk("match_beats_clear", {63'h0, irq}, 64'h1);
        cyc(1'b1, 1'b1, S_TISR, 32'h1, 64'h10);
        chk("held_match_read", {32'h0, rdata}, 64'h1);
        chk("held_match_irq", {63'h0, irq}, 64'h1);

        // Coherent 64-bit counter read through the snapshot
        cyc(1'b0, 1'b1, S_TDR0, 32'h0, 64'h0000_0001_FFFF_FFFF);
        chk("tdr0_low", {32'h0, rdata}, 64'hFFFF_FFFF);
        cyc(1'b0, 1'b1, S_TDR1, 32'h0, 64'h0000_0002_0000_0000);
        chk("tdr1_snap", {32'h0, rdata}, 64'h1);
        cyc(1'b1, 1'b1, S_TDR1, 32'hABCD, 64'h0000_0005_0000_0000);
        chk("tdr1_write_ignored", {32'h0, rdata}, 64'h1);

        // Read-during-write returns the old value
        cyc(1'b1, 1'b1, S_TCMP0, 32'h55, 64'h0);
        chk("rdw_old", {32'h0, rdata}, 64'h10);
        cyc(1'b0, 1'b1, S_TCMP0, 32'h0, 64'h0);
        chk("rdw_new", {32'h0, rdata}, 64'h55);

        // Wrap value matches like any other
        cyc(1'b1, 1'b0, S_TCMP0, 32'hFFFF_FFFF, 64'h0);
        cyc(1'b1, 1'b0, S_TCMP1, 32'hFFFF_FFFF, 64'h0);
        cyc(1'b1, 1'b0, S_TISR, 32'h1, 64'h0);
        chk("wrap_pre", {63'h0, irq}, 64'h0);
        cyc(1'b0, 1'b0, 8'h00, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_match", {63'h0, irq}, 64'h1);

        // Asynchronous reset between edges with irq asserted
        cyc(1'b0, 1'b1, S_TDR0, 32'h0, 64'h0000_0007_0000_0003);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_irq", {63'h0, irq}, 64'h0);
        chk("async_rdata", {32'h0, rdata}, 64'h0);
        #2;
        rst_n = 1'b1;
        model_reset();
        cyc(1'b0, 1'b1, S_TCMP0, 32'h0, 64'h0);
        chk("post_rst_tcmp0", {32'h0, rdata}, 64'hFFFF_FFFF);
        cyc(1'b0, 1'b1, S_TCMP1, 32'h0, 64'h0);
        chk("post_rst_tcmp1", {32'h0, rdata}, 64'hFFFF_FFFF);
        cyc(1'b0, 1'b1, S_TDR1, 32'h0, 64'h0);
        chk("post_rst_snap", {32'h0, rdata}, 64'h0);

        // Random register traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) sel = 8'h00;
            else sel = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) wd = $urandom;
            else wd = $urandom_range(0, 40);
            case ($urandom_range(0, 2))
                0:       c = m_tcmp;
                1:       c = {32'($urandom_range(0, 1)), 32'($urandom_range(0, 40))};
                default: c = {$urandom, $urandom};
            endcase
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sel, wd, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_cmp_irq.md
TIMER_CMP_IRQ -- requirements
Module: timer_cmp_irq

Interface
REQ-001 Parameter: DATA_SIZE, 32, register/bus data width.
REQ-002 Parameter: CNT_SIZE, 64, counter width; fixed at 2*DATA_SIZE.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: wr_en  input  1  register write strobe, one cycle per access.
REQ-006 Port: rd_en  input  1  register read strobe, one cycle per access.
REQ-007 Port: reg_sel  input  8  one-hot register select: [1] TDR0, [2] TDR1, [3] TCMP0, [4] TCMP1, [5] TIER, [6] TISR; other bits ignored.
REQ-008 Port: wdata  input  DATA_SIZE  write data.
REQ-009 Port: cnt  input  CNT_SIZE  live counter value from the timer counter.
REQ-010 Port: rdata  output  DATA_SIZE  registered read data.
REQ-011 Port: irq  output  1  level interrupt, TISR[0] & TIER[0].

Function
REQ-012 The block SHALL hold a 64-bit compare register: TCMP0 = bits [31:0], TCMP1 = bits [63:32], each written independently by wr_en with its reg_sel bit.
REQ-013 The block SHALL hold TIER (only bit 0 stored, writable) and TISR (only bit 0 stored, sticky).
REQ-014 A match SHALL be cnt == stored compare value, using the compare value as registered before the current edge; TISR[0] SHALL be set on the edge following a cycle in which the match holds.
REQ-015 Writing TISR with wdata[0]=1 SHALL clear TISR[0]; wdata[0]=0 SHALL leave it unchanged.
REQ-016 On the same edge, match-set SHALL win over write-1-clear.
REQ-017 TISR[0] SHALL stay set for as long as the match holds, even after clears.
REQ-018 irq SHALL be combinational from registered TISR[0] and TIER[0]; no extra delay.
REQ-019 Reads SHALL have 1-cycle latency: rdata updates on the edge that samples rd_en and holds until the next read edge.
REQ-020 Read map: TDR0 -> cnt[31:0]; TDR1 -> snapshot high word; TCMP0/TCMP1 -> compare halves; TIER -> {31'b0, TIER[0]}; TISR -> {31'b0, TISR[0]}; none or other select -> 0.
REQ-021 A TDR0 read SHALL capture cnt[63:32] into a 32-bit snapshot register on the same edge, so a following TDR1 read returns the high word coherent with the low word, whatever the counter does in between.
REQ-022 A TDR1 read with no prior TDR0 read since reset SHALL return the snapshot reset value 0.
REQ-023 TDR0/TDR1 writes SHALL have no effect on this block; the counter owns them.
REQ-024 For simultaneous wr_en and rd_en to the same register, rdata SHALL return the pre-write value.
REQ-025 Compare wrap-around is not special: a match at cnt = 64'hFFFF_FFFF_FFFF_FFFF sets TISR like any other value.

Reset
REQ-026 On rst_n low, asynchronously: TCMP = 64'hFFFF_FFFF_FFFF_FFFF, TIER = 0, TISR = 0, snapshot = 0, rdata = 0; irq therefore 0.
REQ-027 Reset asserted mid-operation SHALL discard pending flags and snapshot; the first edge after release SHALL behave as after power-up.

Structure
REQ-028 Register select bit indices (TDR0=1 ... TISR=6) and the TCMP reset constant SHALL live in the shared timer package, used by both the counter and this block.
REQ-029 The block SHALL be one module with no sub-modules; the compare and the read mux stay inline.

Verification
REQ-030 Write TCMP0=0x10, TCMP1=0, TIER=1; drive cnt 0x0E..0x12 -> TISR[0] and irq go 1 on the edge after cnt=0x10 and stay 1.
REQ-031 With TISR set and cnt != compare, write TISR=1 -> TISR 0 and irq 0 next cycle; write TISR=0 -> no change.
REQ-032 Hold cnt == compare and write TISR=1 on the same edge -> TISR stays 1.
REQ-033 cnt=0x0000_0001_FFFF_FFFF, read TDR0 -> rdata 0xFFFF_FFFF; cnt becomes 0x0000_0002_0000_0000; read TDR1 -> rdata 0x0000_0001.
REQ-034 Assert rst_n low between clock edges with TISR=1 and TIER=1 -> irq 0 immediately; read TCMP0/TCMP1 after release -> 0xFFFF_FFFF each.
REQ-035 Read TCMP0 and write TCMP0=0x55 in the same cycle -> rdata old value; next read -> 0x55.
